// File: rtl/crop_pkg.sv
// -----------------------------------------------------------------------------
// crop_pkg
// Shared types and constants for the crop sequencer slice.
//   crop_coord_t : packed {Y1, X1} crop origin, Y1 in the MSBs
//   crop_state_t : sequencer states LOAD / ISSUE / STREAM
//   IN_PIX, OUT_PIX, CNT_W : pixel counts and counter width of the default
//                            100x160 -> 48x48 configuration
//   min_row / min_col : saturating helpers used by the optional origin clamp
// -----------------------------------------------------------------------------
package crop_pkg;

  localparam int DEF_IN_ROWS  = 100;
  localparam int DEF_IN_COLS  = 160;
  localparam int DEF_OUT_ROWS = 48;
  localparam int DEF_OUT_COLS = 48;
  localparam int ROW_W        = 10;
  localparam int COL_W        = 10;

  localparam int IN_PIX  = DEF_IN_ROWS * DEF_IN_COLS;
  localparam int OUT_PIX = DEF_OUT_ROWS * DEF_OUT_COLS;
  localparam int CNT_W   = $clog2(IN_PIX + 1);

  typedef struct packed {
    logic [ROW_W-1:0] y1;
    logic [COL_W-1:0] x1;
  } crop_coord_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2
  } crop_state_t;

  function automatic logic [ROW_W-1:0] min_row(input logic [ROW_W-1:0] v,
                                               input logic [ROW_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [COL_W-1:0] min_col(input logic [COL_W-1:0] v,
                                               input logic [COL_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/crop_table.sv
// -----------------------------------------------------------------------------
// crop_table
// NUM_CROPS-entry register file of crop origins.
//   clk, reset (async, active low)
//   i_we / i_waddr / i_wdata : write port (one entry per cycle)
//   i_raddr / o_rdata        : combinational read by index
// Optional macro CROP_SEQ_CLAMP_EN: when defined, Y1/X1 are saturated at write
// time so the crop window always lies inside the input frame.
// -----------------------------------------------------------------------------
module crop_table
  import crop_pkg::*;
#(
  parameter int NUM_CROPS = 4,
  parameter int IDX_W     = 2,
  parameter int IN_ROWS   = 100,
  parameter int IN_COLS   = 160,
  parameter int OUT_ROWS  = 48,
  parameter int OUT_COLS  = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  crop_coord_t      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output crop_coord_t      o_rdata
);

`ifdef CROP_SEQ_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  // Largest origins that still keep the whole crop inside the frame.
  localparam logic [ROW_W-1:0] Y1_MAX = ROW_W'(IN_ROWS - OUT_ROWS);
  localparam logic [COL_W-1:0] X1_MAX = COL_W'(IN_COLS - OUT_COLS);

  crop_coord_t r_tab [NUM_CROPS];
  crop_coord_t w_wr_val;

  // Value actually stored: raw origin, or saturated origin in clamp builds.
  always_comb begin
    w_wr_val = i_wdata;
    if (CLAMP_EN) begin
      w_wr_val.y1 = min_row(i_wdata.y1, Y1_MAX);
      w_wr_val.x1 = min_col(i_wdata.x1, X1_MAX);
    end else begin
      w_wr_val = i_wdata;
    end
  end

  // Table storage; contents are cleared on reset only for determinism.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CROPS; i++) begin
        r_tab[i] <= {(ROW_W + COL_W){1'b0}};
      end
    end else if (i_we) begin
      r_tab[i_waddr] <= w_wr_val;
    end
  end

  assign o_rdata = r_tab[i_raddr];

endmodule

// File: rtl/crop_sequencer.sv
// -----------------------------------------------------------------------------
// crop_sequencer
// Controller in front of crop_plus_fifo. Loads a table of crop origins over a
// config stream, then for every frame issues one origin on crop_Y1/crop_X1,
// gates the frame's pixels into the datapath, counts the cropped pixels coming
// back, tags them with TLAST/TUSER and moves round-robin to the next origin.
// Ports:
//   clk, reset (async, active low)
//   cfg_*            : {Y1,X1} table load stream, TLAST ends the table
//   frame_in_*       : raster input pixels
//   crop_pixel_in_*  : pixels to the datapath (combinational pass-through)
//   crop_Y1_*/X1_*   : crop origin to the datapath
//   crop_pixel_out_* : cropped pixels from the datapath
//   pixel_out_*      : cropped pixels out, TLAST = last of crop, TUSER = index
//   frame_done       : one-cycle pulse per completed crop
//   busy             : high whenever the table is not being loaded
// Optional macro CROP_SEQ_CLAMP_EN (handled in crop_table): clamp origins.
// -----------------------------------------------------------------------------
module crop_sequencer
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int NUM_CROPS        = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] cfg_TDATA,
  input  logic                                         cfg_TVALID,
  input  logic                                         cfg_TLAST,
  output logic                                         cfg_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]                   frame_in_TDATA,
  input  logic                                         frame_in_TVALID,
  output logic                                         frame_in_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]                   crop_pixel_in_TDATA,
  output logic                                         crop_pixel_in_TVALID,
  input  logic                                         crop_pixel_in_TREADY,
  output logic [IMG_ROW_BITWIDTH-1:0]                  crop_Y1_TDATA,
  output logic                                         crop_Y1_TVALID,
  input  logic                                         crop_Y1_TREADY,
  output logic [IMG_COL_BITWIDTH-1:0]                  crop_X1_TDATA,
  output logic                                         crop_X1_TVALID,
  input  logic                                         crop_X1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]                   crop_pixel_out_TDATA,
  input  logic                                         crop_pixel_out_TVALID,
  output logic                                         crop_pixel_out_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]                   pixel_out_TDATA,
  output logic                                         pixel_out_TVALID,
  input  logic                                         pixel_out_TREADY,
  output logic                                         pixel_out_TLAST,
  output logic [((NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1)-1:0] pixel_out_TUSER,
  output logic                                         frame_done,
  output logic                                         busy
);

  localparam int IDX_W     = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;
  localparam int FRAME_PIX = IN_ROWS * IN_COLS;
  localparam int CROP_PIX  = OUT_ROWS * OUT_COLS;
  localparam int CW        = $clog2(FRAME_PIX + 1);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_CROPS - 1);
  localparam logic [CW-1:0]    IN_LAST   = CW'(FRAME_PIX - 1);
  localparam logic [CW-1:0]    OUT_LAST  = CW'(CROP_PIX - 1);

  crop_state_t      r_state;
  crop_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] r_last_idx;   // n_entries - 1
  logic [IDX_W-1:0] r_cur;
  logic             r_y1_vld;
  logic             r_x1_vld;
  logic             r_y1_done;
  logic             r_x1_done;
  logic [CW-1:0]    r_in_cnt;
  logic [CW-1:0]    r_out_cnt;
  logic             r_in_done;
  logic             r_out_done;
  logic             r_frame_done;

  logic        w_load;
  logic        w_stream;
  logic        w_cfg_hs;
  logic        w_load_end;
  logic        w_y1_hs;
  logic        w_x1_hs;
  logic        w_in_hs;
  logic        w_out_hs;
  crop_coord_t w_cfg_coord;
  crop_coord_t w_rd;

  assign w_load      = (r_state == LOAD);
  assign w_stream    = (r_state == STREAM);
  assign w_cfg_coord = cfg_TDATA;
  assign w_cfg_hs    = w_load & cfg_TVALID;
  // A full table ends the load regardless of TLAST.
  assign w_load_end  = w_cfg_hs & (cfg_TLAST | (r_wr_ptr == LAST_SLOT));
  assign w_y1_hs     = r_y1_vld & crop_Y1_TREADY;
  assign w_x1_hs     = r_x1_vld & crop_X1_TREADY;

  crop_table #(
    .NUM_CROPS (NUM_CROPS),
    .IDX_W     (IDX_W),
    .IN_ROWS   (IN_ROWS),
    .IN_COLS   (IN_COLS),
    .OUT_ROWS  (OUT_ROWS),
    .OUT_COLS  (OUT_COLS)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_cfg_hs),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_cfg_coord),
    .i_raddr (r_cur),
    .o_rdata (w_rd)
  );

  // Pixel paths are pure combinational gating so they add no latency.
  assign cfg_TREADY            = w_load;
  assign crop_pixel_in_TDATA   = frame_in_TDATA;
  assign crop_pixel_in_TVALID  = w_stream & frame_in_TVALID & ~r_in_done;
  assign frame_in_TREADY       = w_stream & crop_pixel_in_TREADY & ~r_in_done;
  assign pixel_out_TDATA       = crop_pixel_out_TDATA;
  assign pixel_out_TVALID      = w_stream & crop_pixel_out_TVALID & ~r_out_done;
  assign crop_pixel_out_TREADY = w_stream & pixel_out_TREADY & ~r_out_done;
  assign pixel_out_TLAST       = w_stream & ~r_out_done & (r_out_cnt == OUT_LAST);
  assign pixel_out_TUSER       = w_stream ? r_cur : {IDX_W{1'b0}};
  assign crop_Y1_TVALID        = r_y1_vld;
  assign crop_X1_TVALID        = r_x1_vld;
  assign crop_Y1_TDATA         = w_rd.y1;
  assign crop_X1_TDATA         = w_rd.x1;
  assign frame_done            = r_frame_done;
  assign busy                  = ~w_load;

  assign w_in_hs  = crop_pixel_in_TVALID & crop_pixel_in_TREADY;
  assign w_out_hs = pixel_out_TVALID & pixel_out_TREADY;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD: begin
        if (w_load_end) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      ISSUE: begin
        if (r_y1_done && r_x1_done) begin
          w_state_nxt = STREAM;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      STREAM: begin
        if (r_in_done && r_out_done) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = STREAM;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Table pointers, origin handshakes, pixel counters and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= {IDX_W{1'b0}};
      r_last_idx   <= {IDX_W{1'b0}};
      r_cur        <= {IDX_W{1'b0}};
      r_y1_vld     <= 1'b0;
      r_x1_vld     <= 1'b0;
      r_y1_done    <= 1'b0;
      r_x1_done    <= 1'b0;
      r_in_cnt     <= {CW{1'b0}};
      r_out_cnt    <= {CW{1'b0}};
      r_in_done    <= 1'b0;
      r_out_done   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_cfg_hs) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load_end) begin
              r_last_idx <= r_wr_ptr;
              r_cur      <= {IDX_W{1'b0}};
              r_wr_ptr   <= {IDX_W{1'b0}};
            end
          end
        end
        ISSUE: begin
          if (r_y1_done && r_x1_done) begin
            r_y1_done <= 1'b0;
            r_x1_done <= 1'b0;
          end else begin
            // Each channel raises VALID once and retires independently.
            if (w_y1_hs) begin
              r_y1_vld  <= 1'b0;
              r_y1_done <= 1'b1;
            end else if (!r_y1_done) begin
              r_y1_vld <= 1'b1;
            end
            if (w_x1_hs) begin
              r_x1_vld  <= 1'b0;
              r_x1_done <= 1'b1;
            end else if (!r_x1_done) begin
              r_x1_vld <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            if (r_in_cnt == IN_LAST) begin
              r_in_done <= 1'b1;
            end
          end
          if (w_out_hs) begin
            r_out_cnt <= r_out_cnt + 1'b1;
            if (r_out_cnt == OUT_LAST) begin
              r_out_done <= 1'b1;
            end
          end
          // Both sides finished: retire the crop and step round-robin.
          if (r_in_done && r_out_done) begin
            r_frame_done <= 1'b1;
            r_in_cnt     <= {CW{1'b0}};
            r_out_cnt    <= {CW{1'b0}};
            r_in_done    <= 1'b0;
            r_out_done   <= 1'b0;
            r_cur        <= (r_cur == r_last_idx) ? {IDX_W{1'b0}} : (r_cur + 1'b1);
          end
        end
        default: begin
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crop_sequencer.sv
// Self-checking bench for crop_sequencer. A behavioural crop datapath sits
// behind the DUT; expected crops are generated from the table entries.
module tb_crop_sequencer;

  localparam int PW   = 16;
  localparam int IR   = 24;
  localparam int IC   = 32;
  localparam int OR_  = 6;
  localparam int OC   = 8;
  localparam int NC   = 4;
  localparam int UW   = 2;
  localparam int FPIX = IR * IC;
  localparam int CPIX = OR_ * OC;

  logic          clk = 1'b0;
  logic          reset;
  logic [19:0]   cfg_TDATA;
  logic          cfg_TVALID, cfg_TLAST, cfg_TREADY;
  logic [PW-1:0] frame_in_TDATA;
  logic          frame_in_TVALID, frame_in_TREADY;
  logic [PW-1:0] crop_pixel_in_TDATA;
  logic          crop_pixel_in_TVALID, crop_pixel_in_TREADY;
  logic [9:0]    crop_Y1_TDATA, crop_X1_TDATA;
  logic          crop_Y1_TVALID, crop_Y1_TREADY, crop_X1_TVALID, crop_X1_TREADY;
  logic [PW-1:0] crop_pixel_out_TDATA;
  logic          crop_pixel_out_TVALID, crop_pixel_out_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic          pixel_out_TVALID, pixel_out_TREADY, pixel_out_TLAST;
  logic [UW-1:0] pixel_out_TUSER;
  logic          frame_done, busy;

  crop_sequencer #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR_), .OUT_COLS(OC),
    .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10), .NUM_CROPS(NC)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_TDATA(cfg_TDATA), .cfg_TVALID(cfg_TVALID), .cfg_TLAST(cfg_TLAST), .cfg_TREADY(cfg_TREADY),
    .frame_in_TDATA(frame_in_TDATA), .frame_in_TVALID(frame_in_TVALID), .frame_in_TREADY(frame_in_TREADY),
    .crop_pixel_in_TDATA(crop_pixel_in_TDATA), .crop_pixel_in_TVALID(crop_pixel_in_TVALID),
    .crop_pixel_in_TREADY(crop_pixel_in_TREADY),
    .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
    .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
    .crop_pixel_out_TDATA(crop_pixel_out_TDATA), .crop_pixel_out_TVALID(crop_pixel_out_TVALID),
    .crop_pixel_out_TREADY(crop_pixel_out_TREADY),
    .pixel_out_TDATA(pixel_out_TDATA), .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TREADY(pixel_out_TREADY), .pixel_out_TLAST(pixel_out_TLAST),
    .pixel_out_TUSER(pixel_out_TUSER), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
    int user;
  } exp_t;

  exp_t exp_q[$];
  int   exp_y1_q[$];
  int   exp_x1_q[$];
  int   dp_q[$];
  int   tab_y[8];
  int   tab_x[8];
  int   dp_y1 = 0, dp_x1 = 0;
  int   src_idx = 0, src_frames = 0;
  bit   rnd = 1'b0, y1_hold = 1'b0;
  bit   hs_src = 1'b0, hs_dpo = 1'b0, hs_y1 = 1'b0, hs_x1 = 1'b0;
  int   cap_src = 0, cap_y1 = 0, cap_x1 = 0;
  int   done_cnt = 0, in_frame_cnt = 0, out_crop_cnt = 0, y1_seen = 0, x1_seen = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit coin();
    return !rnd || ($urandom_range(0, 3) != 0);
  endfunction

  // Environment: pixel source, behavioural crop datapath and output sink.
  // Drives at negedge, samples handshakes 1 time unit later (stable until posedge).
  initial begin
    forever begin
      @(negedge clk);
      if (hs_src) begin
        if ((cap_src / IC) >= dp_y1 && (cap_src / IC) < dp_y1 + OR_ &&
            (cap_src % IC) >= dp_x1 && (cap_src % IC) < dp_x1 + OC)
          dp_q.push_back(cap_src);
        src_idx++;
        in_frame_cnt++;
        if (src_idx == FPIX) begin
          src_idx = 0;
          if (src_frames > 0) src_frames--;
        end
      end
      if (hs_dpo) void'(dp_q.pop_front());
      if (hs_y1) dp_y1 = cap_y1;
      if (hs_x1) dp_x1 = cap_x1;

      if (!(frame_in_TVALID && !hs_src)) frame_in_TVALID = (src_frames > 0) && coin();
      frame_in_TDATA = PW'(src_idx);
      crop_pixel_in_TREADY = coin();
      if (!(crop_pixel_out_TVALID && !hs_dpo)) crop_pixel_out_TVALID = (dp_q.size() > 0) && coin();
      crop_pixel_out_TDATA = (dp_q.size() > 0) ? PW'(dp_q[0]) : {PW{1'b0}};
      pixel_out_TREADY = coin();
      crop_Y1_TREADY = y1_hold ? 1'b0 : coin();
      crop_X1_TREADY = y1_hold ? 1'b1 : coin();

      #1;
      hs_src  = frame_in_TVALID && frame_in_TREADY;
      cap_src = src_idx;
      if (hs_src) begin
        chk("pass_in_data", crop_pixel_in_TDATA, src_idx);
        chk("pass_in_vld", crop_pixel_in_TVALID, 1);
      end
      hs_dpo = crop_pixel_out_TVALID && crop_pixel_out_TREADY;
      if (hs_dpo) begin
        chk("pout_vld", pixel_out_TVALID, 1);
        if (exp_q.size() == 0) begin
          chk("pout_extra", pixel_out_TDATA, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pout_data", pixel_out_TDATA, e.data);
          chk("pout_last", pixel_out_TLAST, e.last);
          chk("pout_user", pixel_out_TUSER, e.user);
        end
        out_crop_cnt++;
        if (pixel_out_TLAST) begin
          chk("crop_len", out_crop_cnt, CPIX);
          out_crop_cnt = 0;
        end
      end
      hs_y1  = crop_Y1_TVALID && crop_Y1_TREADY;
      cap_y1 = crop_Y1_TDATA;
      if (hs_y1) begin
        y1_seen++;
        if (exp_y1_q.size() == 0) chk("y1_extra", cap_y1, 32'hFFFF_FFFF);
        else chk("y1_issue", cap_y1, exp_y1_q.pop_front());
      end
      hs_x1  = crop_X1_TVALID && crop_X1_TREADY;
      cap_x1 = crop_X1_TDATA;
      if (hs_x1) begin
        x1_seen++;
        if (exp_x1_q.size() == 0) chk("x1_extra", cap_x1, 32'hFFFF_FFFF);
        else chk("x1_issue", cap_x1, exp_x1_q.pop_front());
      end
      if (frame_done) begin
        done_cnt++;
        chk("in_per_frame", in_frame_cnt, FPIX);
        in_frame_cnt = 0;
      end
    end
  end

  task automatic push_issue(input int y, input int x);
    exp_y1_q.push_back(y);
    exp_x1_q.push_back(x);
  endtask

  // Golden crop: row-major window of raster indices at origin (y, x).
  task automatic push_crop(input int y, input int x, input int idx);
    exp_t e;
    push_issue(y, x);
    for (int r = 0; r < OR_; r++) begin
      for (int c = 0; c < OC; c++) begin
        e.data = (y + r) * IC + x + c;
        e.last = (r == OR_ - 1) && (c == OC - 1);
        e.user = idx;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk_rst_vals();
    chk("rst_cfg_rdy", cfg_TREADY, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_y1_vld", crop_Y1_TVALID, 0);
    chk("rst_x1_vld", crop_X1_TVALID, 0);
    chk("rst_cin_vld", crop_pixel_in_TVALID, 0);
    chk("rst_pout_vld", pixel_out_TVALID, 0);
    chk("rst_fin_rdy", frame_in_TREADY, 0);
    chk("rst_cout_rdy", crop_pixel_out_TREADY, 0);
    chk("rst_tlast", pixel_out_TLAST, 0);
    chk("rst_tuser", pixel_out_TUSER, 0);
  endtask

  // Assert reset (called at posedge+2), clear all bench state, check, release.
  task automatic do_reset();
    reset = 1'b0;
    cfg_TVALID = 1'b0; cfg_TLAST = 1'b0; cfg_TDATA = 20'd0;
    frame_in_TVALID = 1'b0; crop_pixel_out_TVALID = 1'b0;
    src_frames = 0; src_idx = 0;
    hs_src = 1'b0; hs_dpo = 1'b0; hs_y1 = 1'b0; hs_x1 = 1'b0;
    exp_q.delete(); exp_y1_q.delete(); exp_x1_q.delete(); dp_q.delete();
    done_cnt = 0; in_frame_cnt = 0; out_crop_cnt = 0; y1_seen = 0; x1_seen = 0;
    y1_hold = 1'b0;
    #1;
    chk_rst_vals();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Send n beats from tab_y/tab_x; TLAST on the final one if requested.
  task automatic load_beats(input int n, input bit last_final, input int n_ready);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_TVALID = 1'b1;
      cfg_TDATA  = {10'(tab_y[i]), 10'(tab_x[i])};
      cfg_TLAST  = last_final && (i == n - 1);
      #1;
      chk("cfg_ready", cfg_TREADY, (i < n_ready) ? 1 : 0);
    end
    @(negedge clk);
    cfg_TVALID = 1'b0;
    cfg_TLAST  = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < budget) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("frames_done", done_cnt, target);
    repeat (40) @(posedge clk);
    #2;
    chk("exp_pix_left", exp_q.size(), 0);
    chk("exp_y1_left", exp_y1_q.size(), 0);
    chk("exp_x1_left", exp_x1_q.size(), 0);
    chk("dp_left", dp_q.size(), 0);
  endtask

  initial begin
    int cy, cx, cyc;
    reset = 1'b0;
    cfg_TVALID = 1'b0; cfg_TLAST = 1'b0; cfg_TDATA = 20'd0;
    frame_in_TVALID = 1'b0; frame_in_TDATA = {PW{1'b0}};
    crop_pixel_in_TREADY = 1'b0; crop_pixel_out_TVALID = 1'b0;
    crop_pixel_out_TDATA = {PW{1'b0}}; pixel_out_TREADY = 1'b0;
    crop_Y1_TREADY = 1'b0; crop_X1_TREADY = 1'b0;
    @(posedge clk);
    #2;
    do_reset();

    // Three entries with TLAST, four full-rate frames: 0,1,2,0 then 1 issued.
    rnd = 1'b0;
    tab_y[0] = 0;  tab_x[0] = 0;
    tab_y[1] = 9;  tab_x[1] = 12;
    tab_y[2] = 18; tab_x[2] = 24;
    load_beats(3, 1'b1, 3);
    chk("busy_after_load", busy, 1);
    for (int k = 0; k < 4; k++) push_crop(tab_y[k % 3], tab_x[k % 3], k % 3);
    push_issue(tab_y[1], tab_x[1]);
    src_frames = 4;
    wait_done(4, 20000);

    // Five beats, no TLAST: table fills at four, fifth refused; Y1 stalled.
    @(posedge clk);
    #2;
    do_reset();
    rnd = 1'b1;
    y1_hold = 1'b1;
    tab_y[0] = 2;  tab_x[0] = 3;
    tab_y[1] = 5;  tab_x[1] = 7;
    tab_y[2] = 11; tab_x[2] = 13;
    tab_y[3] = 17; tab_x[3] = 23;
    tab_y[4] = 1;  tab_x[4] = 1;
    for (int k = 0; k < 4; k++) push_crop(tab_y[k], tab_x[k], k);
    push_issue(tab_y[0], tab_x[0]);
    src_frames = 4;
    load_beats(5, 1'b0, 4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      chk("in_blocked_issue", frame_in_TREADY, 0);
    end
    chk("x1_first", x1_seen, 1);
    chk("y1_held", y1_seen, 0);
    y1_hold = 1'b0;
    wait_done(4, 40000);

    // Reset mid-stream, then reload: next frame must come from entry 0.
    @(posedge clk);
    #2;
    do_reset();
    tab_y[0] = 3;  tab_x[0] = 5;
    tab_y[1] = 10; tab_x[1] = 20;
    push_crop(tab_y[0], tab_x[0], 0);
    src_frames = 2;
    load_beats(2, 1'b1, 2);
    cyc = 0;
    while (src_idx < (FPIX * 5) / 16 && cyc < 10000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("mid_stream_reached", (src_idx >= (FPIX * 5) / 16) ? 1 : 0, 1);
    do_reset();
    tab_y[0] = 4;  tab_x[0] = 6;
    tab_y[1] = 12; tab_x[1] = 2;
    push_crop(tab_y[0], tab_x[0], 0);
    push_issue(tab_y[1], tab_x[1]);
    src_frames = 1;
    load_beats(2, 1'b1, 2);
    wait_done(1, 10000);

    // Out-of-range origin: clamped only when the clamp build option is on.
    @(posedge clk);
    #2;
    do_reset();
    rnd = 1'b0;
`ifdef CROP_SEQ_CLAMP_EN
    cy = IR - OR_;
    cx = IC - OC;
`else
    cy = 90;
    cx = 150;
`endif
    tab_y[0] = 90; tab_x[0] = 150;
    push_issue(cy, cx);
    load_beats(1, 1'b1, 1);
    cyc = 0;
    while ((y1_seen == 0 || x1_seen == 0) && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("clamp_y1", cap_y1, cy);
    chk("clamp_x1", cap_x1, cx);
    chk("clamp_issue_left", exp_y1_q.size() + exp_x1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crop_sequencer.md
Name: crop_sequencer

Overview:
- Controller in front of crop_plus_fifo. Holds a table of up to NUM_CROPS crop origins (Y1, X1), loaded over a config stream.
- For each incoming frame, issues one table entry to the crop datapath's crop_Y1/crop_X1 AXI-stream ports, then gates the frame's pixels into the datapath.
- Counts the cropped pixels coming out, marks them with TLAST and a crop index, and advances round-robin to the next entry on the next frame.

Parameters:
- PIXEL_BIT_WIDTH, 16, pixel data width
- IN_ROWS, 100, input frame rows
- IN_COLS, 160, input frame columns
- OUT_ROWS, 48, crop rows
- OUT_COLS, 48, crop columns
- IMG_ROW_BITWIDTH, 10, Y1 width
- IMG_COL_BITWIDTH, 10, X1 width
- NUM_CROPS, 4, crop table depth (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_TDATA  in  IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH  {Y1, X1}, with Y1 in the MSBs
- cfg_TVALID / cfg_TLAST  in  1 each  config beat valid / last table entry
- cfg_TREADY  out  1  config accepted
- frame_in_TDATA  in  PIXEL_BIT_WIDTH  raster pixel; frame_in_TVALID in 1; frame_in_TREADY out 1
- crop_pixel_in_TDATA  out  PIXEL_BIT_WIDTH  to datapath; crop_pixel_in_TVALID out 1; crop_pixel_in_TREADY in 1
- crop_Y1_TDATA  out  IMG_ROW_BITWIDTH; crop_Y1_TVALID out 1; crop_Y1_TREADY in 1
- crop_X1_TDATA  out  IMG_COL_BITWIDTH; crop_X1_TVALID out 1; crop_X1_TREADY in 1
- crop_pixel_out_TDATA  in  PIXEL_BIT_WIDTH; crop_pixel_out_TVALID in 1; crop_pixel_out_TREADY out 1
- pixel_out_TDATA  out  PIXEL_BIT_WIDTH; pixel_out_TVALID out 1; pixel_out_TREADY in 1
- pixel_out_TLAST  out  1  last pixel of the crop
- pixel_out_TUSER  out  $clog2(NUM_CROPS) (min 1)  table index of the crop
- frame_done  out  1  one-cycle pulse when a crop completes
- busy  out  1  high in every state except LOAD

Behaviour:
- Reset (reset low): state LOAD, table count 0, pointers 0, all counters 0.
  - All TVALID outputs low, all TREADY outputs low except cfg_TREADY, which is high.
  - frame_done=0, busy=0, TLAST=0, TUSER=0. Table contents are don't-care.
  - Asserting reset mid-frame aborts the frame; the table must be reloaded.
- LOAD:
  - cfg_TREADY=1. Each handshake writes the entry at wr_ptr and increments wr_ptr.
  - Move to ISSUE on a handshake with cfg_TLAST=1, or on the write to index NUM_CROPS-1 (table full; TLAST ignored).
  - n_entries = wr_ptr+1; cur=0.
- ISSUE:
  - crop_Y1_TVALID and crop_X1_TVALID rise the cycle after entry; TDATA comes from entry cur.
  - Each channel completes independently; its TVALID drops the cycle after its handshake.
  - Move to STREAM the cycle after both handshakes are done (simultaneous handshakes allowed).
  - Frame pixels are blocked in this state: frame_in_TREADY=0.
- STREAM, input side:
  - Combinational pass-through: crop_pixel_in_TVALID = frame_in_TVALID & !in_done; frame_in_TREADY = crop_pixel_in_TREADY & !in_done; TDATA passes straight through.
  - in_cnt counts handshakes; in_done is set when in_cnt reaches IN_ROWS*IN_COLS.
- STREAM, output side:
  - Combinational pass-through of crop_pixel_out to pixel_out; TUSER=cur.
  - out_cnt counts handshakes. TLAST=1 when out_cnt==OUT_ROWS*OUT_COLS-1.
  - After the last pixel, crop_pixel_out_TREADY=0.
- Crop completion:
  - When in_done and out_done are both set: frame_done pulses for 1 cycle, counters and flags clear, cur advances (wraps to 0 at n_entries-1), and state returns to ISSUE.
  - The last input and last output may complete in the same cycle.
- Zero added latency on the pixel paths. ISSUE→STREAM overhead is at least 2 cycles.
- Counter width: $clog2(IN_ROWS*IN_COLS+1).
- cfg beats after LOAD are not accepted (cfg_TREADY=0).

Optional Feature:
- Macro: CROP_SEQ_CLAMP_EN.
- Defined: Y1 is clamped to min(Y1, IN_ROWS-OUT_ROWS) and X1 to min(X1, IN_COLS-OUT_COLS) at table write time.
- Undefined: values are stored and issued unchanged.

Decomposition:
- Package crop_pkg holds:
  - typedef crop_coord_t, a packed struct {Y1, X1};
  - the state enum {LOAD, ISSUE, STREAM};
  - localparams IN_PIX, OUT_PIX and CNT_W.
- One sub-module, crop_table: a NUM_CROPS-entry register file with write port, read-by-index port and the optional clamp logic.

Test Plan:
- Load 3 entries {(0,0),(37,59),(52,112)} with TLAST on the 3rd; send 4 frames of index-valued pixels.
  - Expect crops issued in order 0,1,2,0.
  - Expect TUSER 0,1,2,0.
  - Expect 2304 outputs per crop with TLAST on the 2304th.
  - Expect 4 frame_done pulses.
- Load 5 beats with NUM_CROPS=4 and no TLAST.
  - Expect cfg_TREADY low after the 4th beat.
  - Expect the 5th beat not consumed.
  - Expect the crop rotation to cover 4 entries.
- crop_Y1_TREADY held low 20 cycles while crop_X1_TREADY=1.
  - Expect X1 completes first.
  - Expect frame_in_TREADY stays 0 until the Y1 handshake.
  - Expect then exactly 16000 inputs accepted.
- Random valid/ready on every stream.
  - Expect no pixel lost or duplicated.
  - Expect the output sequence to match the golden cropped indices.
- Reset pulsed low mid-STREAM (input pixel 5000).
  - Expect all outputs at reset values, busy=0, cfg_TREADY=1.
  - After reloading the table, expect the next frame cropped from entry 0.
- With CROP_SEQ_CLAMP_EN, load (90,150).
  - Expect Y1=52 and X1=112 issued.
  - Without the macro, expect 90 and 150 issued unchanged.
